// File: rtl/uart_echo_tester_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_echo_tester_if
//  Description : Control/status and serial-line bundle of the UART echo tester.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_echo_tester_if;
    logic        start;
    logic        rx_line;
    logic        tx_line;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [7:0]  last_sent;
    logic [7:0]  last_rcvd;

    // master: the host/echo side; slave: the tester itself
    modport master (
        output start, rx_line,
        input  tx_line, busy, done, pass, err_count, last_sent, last_rcvd
    );
    modport slave (
        input  start, rx_line,
        output tx_line, busy, done, pass, err_count, last_sent, last_rcvd
    );
endinterface
`default_nettype wire

// File: rtl/uart_echo_tester.sv
`default_nettype none
// ============================================================================
//  Module      : uart_echo_tester
//  Description : Sends a byte stream over UART, expects each echo to be byte+1,
//                counts mismatches, framing errors and timeouts.
//                Optional macro RANDOM_PATTERN_EN selects an 8-bit LFSR sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_echo_tester #(
    parameter int         DVSR       = 163,
    parameter int         DBIT       = 8,
    parameter int         SB_TICK    = 16,
    parameter int         NUM_BYTES  = 256,
    parameter logic [7:0] SEED       = 8'h00,
    parameter int         TIMEOUT_TK = 1024
) (
    input wire                clk,
    input wire                reset,
    uart_echo_tester_if.slave bus
);

    localparam int         c_TKW      = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int         c_TOW      = $clog2(TIMEOUT_TK + 1);
    localparam int         c_ALIGN    = 8 - DBIT;
    localparam logic [3:0] c_DATA_END = 4'(DBIT);
    localparam logic [3:0] c_STOP_IDX = 4'(DBIT + 1);
`ifdef RANDOM_PATTERN_EN
    localparam logic [7:0] c_FIRST    = (SEED == 8'h00) ? 8'h01 : SEED;
`else
    localparam logic [7:0] c_FIRST    = SEED;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEND = 3'd1,
        S_WAIT = 3'd2,
        S_NEXT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             r_state, w_state_next;
    logic [c_TKW-1:0]   r_tick_cnt;
    logic               w_tick;

    logic               r_tx_active, r_tx_line;
    logic [3:0]         r_tx_idx;
    logic [7:0]         r_tx_tk, r_tx_shift;
    logic               w_tx_launch, w_tx_bit_end, w_tx_frame_end;

    logic               r_rx_s1, r_rx_s2, r_rx_prev, r_rx_active;
    logic [3:0]         r_rx_idx;
    logic [7:0]         r_rx_tk, r_rx_shift;
    logic               w_rx_done;
    logic [7:0]         w_rx_data;

    logic [7:0]         r_byte, w_byte_adv, w_expect;
    logic [15:0]        r_byte_cnt, r_err_count;
    logic [c_TOW-1:0]   r_to_cnt;
    logic [7:0]         r_last_sent, r_last_rcvd;
    logic               r_busy, r_done, r_pass;
    logic               w_run_start, w_err_add, w_rcvd_load;

    assign w_tick = (r_tick_cnt == c_TKW'(DVSR - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      r_tick_cnt <= '0;
        else if (w_tick) r_tick_cnt <= '0;
        else             r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    // ---------------- transmitter ----------------
    assign w_tx_launch    = (r_state == S_SEND) && !r_tx_active && w_tick;
    assign w_tx_bit_end   = r_tx_active && w_tick &&
                            ((r_tx_idx == c_STOP_IDX) ? (r_tx_tk == 8'(SB_TICK - 1))
                                                      : (r_tx_tk == 8'd15));
    assign w_tx_frame_end = w_tx_bit_end && (r_tx_idx == c_STOP_IDX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_active <= 1'b0;
            r_tx_idx    <= '0;
            r_tx_tk     <= '0;
            r_tx_shift  <= '0;
            r_tx_line   <= 1'b1;
        end else if (w_tx_launch) begin
            r_tx_active <= 1'b1;
            r_tx_idx    <= '0;
            r_tx_tk     <= '0;
            r_tx_shift  <= r_byte;
            r_tx_line   <= 1'b0;
        end else if (r_tx_active && w_tick) begin
            if (w_tx_bit_end) begin
                r_tx_tk <= '0;
                if (r_tx_idx == c_STOP_IDX) begin
                    r_tx_active <= 1'b0;
                    r_tx_line   <= 1'b1;
                end else if (r_tx_idx == c_DATA_END) begin
                    r_tx_idx  <= c_STOP_IDX;
                    r_tx_line <= 1'b1;
                end else begin
                    r_tx_idx   <= r_tx_idx + 4'd1;
                    r_tx_line  <= r_tx_shift[0];
                    r_tx_shift <= r_tx_shift >> 1;
                end
            end else begin
                r_tx_tk <= r_tx_tk + 8'd1;
            end
        end
    end

    // ---------------- receiver ----------------
    assign w_rx_done = r_rx_active && w_tick && (r_rx_idx == c_STOP_IDX) &&
                       (r_rx_tk == 8'(SB_TICK - 1));
    assign w_rx_data = r_rx_shift >> c_ALIGN;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_rx_active <= 1'b0;
            r_rx_idx    <= '0;
            r_rx_tk     <= '0;
            r_rx_shift  <= '0;
        end else begin
            r_rx_s1   <= bus.rx_line;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            if (!r_rx_active) begin
                if (r_rx_prev && !r_rx_s2) begin
                    r_rx_active <= 1'b1;
                    r_rx_idx    <= '0;
                    r_rx_tk     <= '0;
                end
            end else if (w_tick) begin
                if (r_rx_idx == 4'd0) begin
                    // mid-start re-check rejects short glitches
                    if (r_rx_tk == 8'd7) begin
                        if (r_rx_s2) begin
                            r_rx_active <= 1'b0;
                        end else begin
                            r_rx_idx <= 4'd1;
                            r_rx_tk  <= '0;
                        end
                    end else begin
                        r_rx_tk <= r_rx_tk + 8'd1;
                    end
                end else if (r_rx_idx == c_STOP_IDX) begin
                    if (r_rx_tk == 8'(SB_TICK - 1)) r_rx_active <= 1'b0;
                    else                            r_rx_tk     <= r_rx_tk + 8'd1;
                end else if (r_rx_tk == 8'd15) begin
                    r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                    r_rx_tk    <= '0;
                    r_rx_idx   <= r_rx_idx + 4'd1;
                end else begin
                    r_rx_tk <= r_rx_tk + 8'd1;
                end
            end
        end
    end

    // ---------------- sequencer ----------------
    assign w_expect = r_byte + 8'd1;
`ifdef RANDOM_PATTERN_EN
    assign w_byte_adv = {r_byte[6:0], r_byte[7] ^ r_byte[5] ^ r_byte[4] ^ r_byte[3]};
`else
    assign w_byte_adv = r_byte + 8'd1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_run_start  = 1'b0;
        w_err_add    = 1'b0;
        w_rcvd_load  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_run_start  = 1'b1;
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (w_tx_frame_end) w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_rx_done) begin
                    w_state_next = S_NEXT;
                    if (r_rx_s2) begin
                        w_rcvd_load = 1'b1;
                        w_err_add   = (w_rx_data != w_expect);
                    end else begin
                        w_err_add = 1'b1;
                    end
                end else if (w_tick && (r_to_cnt == c_TOW'(TIMEOUT_TK - 1))) begin
                    w_err_add    = 1'b1;
                    w_state_next = S_NEXT;
                end
            end
            S_NEXT: begin
                w_state_next = (r_byte_cnt == 16'(NUM_BYTES - 1)) ? S_DONE : S_SEND;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_byte      <= '0;
            r_byte_cnt  <= '0;
            r_err_count <= '0;
            r_to_cnt    <= '0;
            r_last_sent <= '0;
            r_last_rcvd <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            if (w_run_start) begin
                r_err_count <= '0;
                r_done      <= 1'b0;
                r_pass      <= 1'b0;
                r_busy      <= 1'b1;
                r_byte      <= c_FIRST;
                r_byte_cnt  <= '0;
            end
            if (w_tx_launch) r_last_sent <= r_byte;
            if (w_tx_frame_end)                       r_to_cnt <= '0;
            else if ((r_state == S_WAIT) && w_tick)   r_to_cnt <= r_to_cnt + 1'b1;
            if (w_rcvd_load) r_last_rcvd <= w_rx_data;
            if (w_err_add && (r_err_count != 16'hFFFF)) r_err_count <= r_err_count + 16'd1;
            if (r_state == S_NEXT) begin
                r_byte_cnt <= r_byte_cnt + 16'd1;
                r_byte     <= w_byte_adv;
            end
            if (r_state == S_DONE) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_pass <= (r_err_count == 16'd0);
            end
        end
    end

    assign bus.tx_line   = r_tx_line;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err_count;
    assign bus.last_sent = r_last_sent;
    assign bus.last_rcvd = r_last_rcvd;

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_tester.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_echo_tester
//  Description : Directed bench with a behavioural UART echo partner and model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_echo_tester;

    localparam int         c_DVSR = 4;
    localparam int         c_NB   = 4;
    localparam int         c_TO   = 400;
    localparam logic [7:0] c_SEED = 8'hFE;
    localparam int         c_BIT  = 16 * c_DVSR;

    localparam int M_PLUS1 = 0;
    localparam int M_SAME  = 1;
    localparam int M_NONE  = 2;
    localparam int M_STOP0 = 3;

    typedef struct packed {
        logic [7:0] val;
        logic       stop;
        logic       glitch;
    } reply_t;

    logic clk = 1'b0;
    logic reset;

    uart_echo_tester_if bus ();

    uart_echo_tester #(
        .DVSR       (c_DVSR),
        .DBIT       (8),
        .SB_TICK    (16),
        .NUM_BYTES  (c_NB),
        .SEED       (c_SEED),
        .TIMEOUT_TK (c_TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         n_chk     = 0;
    int         n_fail    = 0;
    int         mode      = M_PLUS1;
    bit         glitch_en = 1'b0;
    bit         rx_enable = 1'b1;
    int         rx_count  = 0;
    int         m_err     = 0;
    logic [7:0] m_last    = 8'h00;
    logic [7:0] sent_log[$];
    logic [7:0] rcvd_log[$];
    reply_t     tx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Echo partner, receive side: decodes each DUT frame and decides the reply
    initial begin : p_rx
        logic [7:0] b;
        logic       stp;
        logic [7:0] exp_b;
        reply_t     r;
        forever begin
            @(negedge bus.tx_line);
            repeat (c_BIT / 2) @(negedge clk);
            if (bus.tx_line !== 1'b0) continue;
            for (int i = 0; i < 8; i++) begin
                repeat (c_BIT) @(negedge clk);
                b[i] = bus.tx_line;
            end
            repeat (c_BIT) @(negedge clk);
            stp = bus.tx_line;
            if (!rx_enable) continue;
            exp_b = c_SEED + 8'(rx_count);
            check("tx_byte", {24'd0, b}, {24'd0, exp_b});
            check("tx_stop", {31'd0, stp}, 32'd1);
            check("last_sent", {24'd0, bus.last_sent}, {24'd0, exp_b});
            check("err_before_byte", {16'd0, bus.err_count}, m_err);
            check("rcvd_before_byte", {24'd0, bus.last_rcvd}, {24'd0, m_last});
            check("busy_mid_run", {31'd0, bus.busy}, 32'd1);
            sent_log.push_back(b);
            rcvd_log.push_back(bus.last_rcvd);
            r.glitch = glitch_en;
            r.stop   = 1'b1;
            r.val    = b + 8'd1;
            if (mode == M_SAME)                      r.val  = b;
            if ((mode == M_STOP0) && (rx_count == 2)) r.stop = 1'b0;
            if (mode == M_NONE) begin
                m_err++;
            end else begin
                tx_q.push_back(r);
                if (!r.stop) begin
                    m_err++;
                end else begin
                    m_last = r.val;
                    if (r.val != exp_b + 8'd1) m_err++;
                end
            end
            rx_count++;
        end
    end

    // Echo partner, transmit side
    initial begin : p_tx
        reply_t r;
        bus.rx_line = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_q.size() != 0) begin
                r = tx_q.pop_front();
                if (r.glitch) begin
                    repeat (c_BIT) @(negedge clk);
                    bus.rx_line = 1'b0;
                    repeat (c_DVSR) @(negedge clk);
                    bus.rx_line = 1'b1;
                    repeat (c_BIT) @(negedge clk);
                end
                bus.rx_line = 1'b0;
                repeat (c_BIT) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    bus.rx_line = r.val[i];
                    repeat (c_BIT) @(negedge clk);
                end
                bus.rx_line = r.stop;
                repeat (c_BIT) @(negedge clk);
                bus.rx_line = 1'b1;
            end
        end
    end

    // Status rules re-checked whenever any status output changes
    logic [18:0] prev_stat = '0;
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if ({bus.busy, bus.done, bus.pass, bus.err_count} !== prev_stat) begin
                check("pass_rule", {31'd0, bus.pass},
                      {31'd0, (bus.done && (bus.err_count == 16'd0))});
                check("busy_done_exclusive", {31'd0, (bus.busy && bus.done)}, 32'd0);
            end
            prev_stat <= {bus.busy, bus.done, bus.pass, bus.err_count};
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run(input int md, input bit glt, input bit extra_start);
        int cyc;
        mode      = md;
        glitch_en = glt;
        rx_count  = 0;
        m_err     = 0;
        sent_log.delete();
        rcvd_log.delete();
        pulse_start();
        check("busy_after_start", {31'd0, bus.busy}, 32'd1);
        check("done_cleared", {31'd0, bus.done}, 32'd0);
        check("err_cleared", {16'd0, bus.err_count}, 32'd0);
        if (extra_start) begin
            cyc = 0;
            while ((rx_count < 1) && (cyc < 5000)) begin
                @(negedge clk);
                cyc++;
            end
            check("first_byte_seen", {31'd0, (rx_count >= 1)}, 32'd1);
            pulse_start();
        end
        cyc = 0;
        while ((bus.done !== 1'b1) && (cyc < 20000)) begin
            @(negedge clk);
            cyc++;
        end
        check("done_within_budget", {31'd0, bus.done}, 32'd1);
        check("bytes_sent", rx_count, c_NB);
        check("busy_end", {31'd0, bus.busy}, 32'd0);
        check("err_count_model", {16'd0, bus.err_count}, m_err);
        check("pass_model", {31'd0, bus.pass}, {31'd0, (m_err == 0)});
        check("last_rcvd_model", {24'd0, bus.last_rcvd}, {24'd0, m_last});
        check("last_sent_end", {24'd0, bus.last_sent}, {24'd0, c_SEED + 8'(c_NB - 1)});
    endtask

    logic [7:0] lit_tx[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    initial begin : p_main
        int cyc;
        bus.start = 1'b0;
        reset     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_line", {31'd0, bus.tx_line}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_pass", {31'd0, bus.pass}, 32'd0);
        check("rst_err", {16'd0, bus.err_count}, 32'd0);
        check("rst_last_sent", {24'd0, bus.last_sent}, 32'd0);
        check("rst_last_rcvd", {24'd0, bus.last_rcvd}, 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // +1 echo with a WAIT glitch before each echo and a second start mid-SEND
        run(M_PLUS1, 1'b1, 1'b1);
        check("t1_log_size", sent_log.size(), 4);
        for (int i = 0; i < 4; i++) check("t1_tx_literal", {24'd0, sent_log[i]}, {24'd0, lit_tx[i]});
        check("t1_err", {16'd0, bus.err_count}, 32'd0);
        check("t1_pass", {31'd0, bus.pass}, 32'd1);
        check("t1_last_rcvd", {24'd0, bus.last_rcvd}, 32'h02);

        // unchanged echo: every byte is a mismatch
        run(M_SAME, 1'b0, 1'b0);
        check("t2_err", {16'd0, bus.err_count}, 32'd4);
        check("t2_pass", {31'd0, bus.pass}, 32'd0);
        check("t2_last_rcvd", {24'd0, bus.last_rcvd}, 32'h01);

        // silent line: every byte times out
        run(M_NONE, 1'b0, 1'b0);
        check("t3_err", {16'd0, bus.err_count}, 32'd4);
        check("t3_done", {31'd0, bus.done}, 32'd1);

        // framing error on the third byte's echo
        run(M_STOP0, 1'b0, 1'b0);
        check("t4_err", {16'd0, bus.err_count}, 32'd1);
        check("t4_last_rcvd", {24'd0, bus.last_rcvd}, 32'h02);
        check("t4_log_size", rcvd_log.size(), 4);
        check("t4_rcvd_kept", {24'd0, rcvd_log[3]}, 32'h00);

        // reset in the middle of a data bit, then restart
        mode     = M_PLUS1;
        rx_count = 0;
        pulse_start();
        cyc = 0;
        while ((bus.tx_line !== 1'b0) && (cyc < 2000)) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_frame_began", {31'd0, bus.tx_line}, 32'd0);
        repeat (c_BIT * 2 + c_BIT / 2) @(negedge clk);
        rx_enable = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("t5_async_tx_line", {31'd0, bus.tx_line}, 32'd1);
        check("t5_async_busy", {31'd0, bus.busy}, 32'd0);
        check("t5_async_err", {16'd0, bus.err_count}, 32'd0);
        m_last = 8'h00;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (12 * c_BIT) @(negedge clk);
        tx_q.delete();
        rx_enable = 1'b1;
        run(M_PLUS1, 1'b0, 1'b0);
        check("t5_first_byte", {24'd0, sent_log[0]}, 32'hFE);
        check("t5_pass", {31'd0, bus.pass}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
